// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states, ALU
// operation codes, data-processing commands, condition codes and mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM condition field against the stored {N,Z,C,V} flags.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;
  assign {n, z, c, v} = Flags;

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: FSM sequencing, ALU decode, flag storage
// and conditional gating of all architectural write strobes.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W    = 2,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            Cond,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic [3:0]            ALUFlags,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [3:0]            Flags
);

  state_t     state;
  logic       rdy;
  logic       cond_ex;
  logic       rd_pc;
  logic [3:0] cmd;
  logic       s_bit;
  logic [2:0] alu_op;
  logic [2:0] alu_sel;
  logic [1:0] flag_w;
  logic       no_write;

  assign rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];
  assign rd_pc = (Rd == 4'd15);

  cond_check u_cond (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (cond_ex)
  );

  // Unrecognised commands fall through as a harmless ADD with no side effects.
  always_comb begin
    alu_op   = ALU_ADD;
    flag_w   = 2'b00;
    no_write = 1'b1;
    case (cmd)
      CMD_ADD: begin alu_op = ALU_ADD; flag_w = {2{s_bit}};   no_write = 1'b0; end
      CMD_SUB: begin alu_op = ALU_SUB; flag_w = {2{s_bit}};   no_write = 1'b0; end
      CMD_AND: begin alu_op = ALU_AND; flag_w = {s_bit, 1'b0}; no_write = 1'b0; end
      CMD_ORR: begin alu_op = ALU_ORR; flag_w = {s_bit, 1'b0}; no_write = 1'b0; end
      CMD_CMP: begin alu_op = ALU_SUB; flag_w = 2'b11;         no_write = 1'b1; end
      CMD_EOR: begin
        if (ALU_CTRL_W >= 3) begin
          alu_op   = ALU_EOR;
          flag_w   = {s_bit, 1'b0};
          no_write = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      Flags <= 4'b0000;
    end else begin
      case (state)
        S_FETCH:  if (rdy) state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_MEM:  state <= S_MEMADR;
            OP_DP:   state <= Funct[5] ? S_EXECUTEI : S_EXECUTER;
            OP_BR:   state <= S_BRANCH;
            OP_NONE: state <= S_FETCH;
            default: state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= Funct[0] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (rdy) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (rdy) state <= S_FETCH;
        S_EXECUTER, S_EXECUTEI: begin
          state <= S_ALUWB;
          if (cond_ex) begin
            if (flag_w[1]) Flags[3:2] <= ALUFlags[3:2];
            if (flag_w[0]) Flags[1:0] <= ALUFlags[1:0];
          end
        end
        S_ALUWB:  state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    alu_sel   = ALU_ADD;
    ImmSrc    = Op;
    RegSrc    = {(Op == OP_MEM) & ~Funct[0], (Op == OP_BR)};
    case (state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = rdy;
        PCWrite   = rdy;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR:  ALUSrcB = SRCB_IMM;
      S_MEMREAD: AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = cond_ex;
        PCWrite   = cond_ex & rd_pc;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
      end
      S_EXECUTER: alu_sel = alu_op;
      S_EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        alu_sel = alu_op;
      end
      S_ALUWB: begin
        RegWrite = cond_ex & ~no_write;
        PCWrite  = cond_ex & ~no_write & rd_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        PCWrite   = cond_ex;
      end
      default: ;
    endcase
    // Reset overrides the FETCH decode so nothing is written while held.
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign ALUControl = alu_sel[ALU_CTRL_W-1:0];

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances (ALU_CTRL_W=2 and 3) share stimulus
// and are compared every cycle against an instruction-level reference model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;

  logic       pcw2, adr2, mw2, irw2, rw2, asa2;
  logic [1:0] asb2, rs2, imm2, rsrc2, ac2;
  logic [3:0] fl2;
  logic       pcw3, adr3, mw3, irw3, rw3, asa3;
  logic [1:0] asb3, rs3, imm3, rsrc3;
  logic [2:0] ac3;
  logic [3:0] fl3;

  int checks   = 0;
  int failures = 0;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_RESET} phase_t;

  logic [3:0] mflags [2];

  always #5 clk = ~clk;

  multicycle_controller #(.ALU_CTRL_W(2), .MEM_HANDSHAKE(1'b1)) dut2 (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .mem_ready(mem_ready),
    .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2), .RegWrite(rw2),
    .ALUSrcA(asa2), .ALUSrcB(asb2), .ResultSrc(rs2), .ImmSrc(imm2), .RegSrc(rsrc2),
    .ALUControl(ac2), .Flags(fl2)
  );

  multicycle_controller #(.ALU_CTRL_W(3), .MEM_HANDSHAKE(1'b1)) dut3 (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .mem_ready(mem_ready),
    .PCWrite(pcw3), .AdrSrc(adr3), .MemWrite(mw3), .IRWrite(irw3), .RegWrite(rw3),
    .ALUSrcA(asa3), .ALUSrcB(asb3), .ResultSrc(rs3), .ImmSrc(imm3), .RegSrc(rsrc3),
    .ALUControl(ac3), .Flags(fl3)
  );

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ALU code, no-write and flag-write mask for a Funct field at a given ALU width.
  function automatic void alu_info(input logic [5:0] fn, input int w,
                                   output logic [2:0] code, output bit nw,
                                   output logic [1:0] fw);
    logic [3:0] cmd;
    bit s;
    cmd = fn[4:1]; s = fn[0];
    code = 3'd0; nw = 1'b1; fw = 2'b00;
    if (cmd == 4'b0100)      begin code = 3'd0; nw = 1'b0; fw = s ? 2'b11 : 2'b00; end
    else if (cmd == 4'b0010) begin code = 3'd1; nw = 1'b0; fw = s ? 2'b11 : 2'b00; end
    else if (cmd == 4'b0000) begin code = 3'd2; nw = 1'b0; fw = s ? 2'b10 : 2'b00; end
    else if (cmd == 4'b1100) begin code = 3'd3; nw = 1'b0; fw = s ? 2'b10 : 2'b00; end
    else if (cmd == 4'b1010) begin code = 3'd1; nw = 1'b1; fw = 2'b11; end
    else if (cmd == 4'b0001 && w == 3) begin code = 3'd4; nw = 1'b0; fw = s ? 2'b10 : 2'b00; end
  endfunction

  function automatic logic [20:0] expect_vec(input phase_t ph, input bit mr, input int idx);
    logic pcw, adr, mw, irw, rw, asa;
    logic [1:0] asb, rs, imm, rsrc, fw;
    logic [2:0] ac, code;
    bit nw, ce, pc_dst;
    {pcw, adr, mw, irw, rw, asa} = 6'b0;
    asb = 2'd0; rs = 2'd0; ac = 3'd0;
    alu_info(Funct, (idx == 0) ? 2 : 3, code, nw, fw);
    ce     = cond_holds(Cond, mflags[idx]);
    pc_dst = (Rd == 4'd15);
    imm    = Op;
    rsrc   = {Op == 2'b01 && !Funct[0], Op == 2'b10};
    case (ph)
      P_FETCH:    begin asa = 1; asb = 2; rs = 2; irw = mr; pcw = mr; end
      P_RESET:    begin asa = 1; asb = 2; rs = 2; end
      P_DECODE:   begin asa = 1; asb = 2; rs = 2; end
      P_MEMADR:   asb = 1;
      P_MEMREAD:  adr = 1;
      P_MEMWB:    begin rs = 1; rw = ce; pcw = ce && pc_dst; end
      P_MEMWRITE: begin adr = 1; mw = ce; end
      P_EXECR:    ac = code;
      P_EXECI:    begin asb = 1; ac = code; end
      P_ALUWB:    begin rw = ce && !nw; pcw = ce && !nw && pc_dst; end
      P_BRANCH:   begin asb = 1; rs = 2; pcw = ce; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rw, asa, asb, rs, imm, rsrc, ac, mflags[idx]};
  endfunction

  task automatic check(input string tag, input phase_t ph, input bit mr);
    logic [20:0] e0, e1, o0, o1;
    e0 = expect_vec(ph, mr, 0);
    e1 = expect_vec(ph, mr, 1);
    o0 = {pcw2, adr2, mw2, irw2, rw2, asa2, asb2, rs2, imm2, rsrc2, 1'b0, ac2, fl2};
    o1 = {pcw3, adr3, mw3, irw3, rw3, asa3, asb3, rs3, imm3, rsrc3, ac3, fl3};
    checks++;
    assert (o0 === e0) else begin
      failures++;
      $error("FAIL %s/%s w2 observed=%h expected=%h", tag, ph.name(), o0, e0);
    end
    checks++;
    assert (o1 === e1) else begin
      failures++;
      $error("FAIL %s/%s w3 observed=%h expected=%h", tag, ph.name(), o1, e1);
    end
  endtask

  // One clock cycle in a known phase; called at the falling edge.
  task automatic step(input string tag, input phase_t ph, input bit mr);
    logic [3:0] nf [2];
    logic [2:0] code;
    bit nw;
    logic [1:0] fw;
    mem_ready = mr;
    #1 check(tag, ph, mr);
    for (int i = 0; i < 2; i++) begin
      nf[i] = mflags[i];
      if ((ph == P_EXECR || ph == P_EXECI) && cond_holds(Cond, mflags[i])) begin
        alu_info(Funct, (i == 0) ? 2 : 3, code, nw, fw);
        if (fw[1]) nf[i][3:2] = ALUFlags[3:2];
        if (fw[0]) nf[i][1:0] = ALUFlags[1:0];
      end
    end
    @(posedge clk);
    mflags[0] = nf[0];
    mflags[1] = nf[1];
    @(negedge clk);
  endtask

  task automatic run_instr(input string tag, input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r, input logic [3:0] af,
                           input int fstall, input int mstall);
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
    for (int i = 0; i < fstall; i++) step(tag, P_FETCH, 1'b0);
    step(tag, P_FETCH, 1'b1);
    step(tag, P_DECODE, 1'($urandom_range(0, 1)));
    case (o)
      2'b01: begin
        step(tag, P_MEMADR, 1'($urandom_range(0, 1)));
        if (f[0]) begin
          for (int i = 0; i < mstall; i++) step(tag, P_MEMREAD, 1'b0);
          step(tag, P_MEMREAD, 1'b1);
          step(tag, P_MEMWB, 1'($urandom_range(0, 1)));
        end else begin
          for (int i = 0; i < mstall; i++) step(tag, P_MEMWRITE, 1'b0);
          step(tag, P_MEMWRITE, 1'b1);
        end
      end
      2'b00: begin
        step(tag, f[5] ? P_EXECI : P_EXECR, 1'($urandom_range(0, 1)));
        step(tag, P_ALUWB, 1'($urandom_range(0, 1)));
      end
      2'b10: step(tag, P_BRANCH, 1'($urandom_range(0, 1)));
      default: ;
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cmds [6];
    logic [3:0] rc;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
    cmds[3] = 4'b1100; cmds[4] = 4'b1010; cmds[5] = 4'b0001;
    reset = 1'b1; mem_ready = 1'b1;
    Cond = 4'hE; Op = 2'b00; Funct = 6'b001000; Rd = 4'd1; ALUFlags = 4'h0;
    mflags[0] = 4'h0; mflags[1] = 4'h0;
    @(negedge clk);
    #1 check("reset", P_RESET, 1'b1);
    @(negedge clk);
    #1 check("reset_hold", P_RESET, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    run_instr("ADD",  4'hE, 2'b00, 6'b001000, 4'd1,  4'h0, 0, 0);
    run_instr("SUBS", 4'hE, 2'b00, 6'b000101, 4'd2,  4'b0100, 0, 0);
    run_instr("BEQ",  4'h0, 2'b10, 6'b101000, 4'd0,  4'h0, 0, 0);
    run_instr("BNE",  4'h1, 2'b10, 6'b101000, 4'd0,  4'h0, 0, 0);
    run_instr("LDR",  4'hE, 2'b01, 6'b011001, 4'd3,  4'h0, 1, 3);
    run_instr("CMP",  4'hE, 2'b00, 6'b010101, 4'd0,  4'b1001, 0, 0);
    run_instr("ADDPC",4'hE, 2'b00, 6'b001000, 4'd15, 4'h0, 0, 0);
    run_instr("LDRPC",4'hE, 2'b01, 6'b011001, 4'd15, 4'h0, 0, 0);

    // Store interrupted by reset while waiting on memory.
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd4; ALUFlags = 4'h0;
    step("STR", P_FETCH, 1'b1);
    step("STR", P_DECODE, 1'b1);
    step("STR", P_MEMADR, 1'b1);
    mem_ready = 1'b0;
    #1 check("STR", P_MEMWRITE, 1'b0);
    reset = 1'b1;
    mflags[0] = 4'h0; mflags[1] = 4'h0;
    #1 check("STR_rst", P_RESET, 1'b0);
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 check("STR_rst_hold", P_RESET, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    run_instr("EORS", 4'hE, 2'b00, 6'b000011, 4'd5, 4'b1010, 0, 0);
    run_instr("OP11", 4'hE, 2'b11, 6'b111111, 4'd15, 4'h0, 0, 0);
    run_instr("ANDSI",4'hE, 2'b00, 6'b100001, 4'd15, 4'b0111, 0, 0);
    run_instr("STR2", 4'hE, 2'b01, 6'b011000, 4'd6, 4'h0, 0, 2);

    for (int k = 0; k < 60; k++) begin
      logic [5:0] fn;
      fn = 6'($urandom);
      if ($urandom_range(0, 3) != 0) fn[4:1] = cmds[$urandom_range(0, 5)];
      rc = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
      run_instr("rand", rc, 2'($urandom), fn, 4'($urandom), 4'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALU_CTRL_W, default 2, ALUControl width; 2 = ADD/SUB/AND/ORR, 3 adds EOR.
REQ-002 Parameter MEM_HANDSHAKE, default 1; 0 ties mem_ready internally high.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 Cond  in  4  instruction bits 31:28.
REQ-006 Op  in  2  instruction bits 27:26.
REQ-007 Funct  in  6  instruction bits 25:20; Funct[5]=I, Funct[4:1]=cmd, Funct[0]=S (or L for memory).
REQ-008 Rd  in  4  destination register.
REQ-009 ALUFlags  in  4  {N,Z,C,V} from ALU, valid during EXECUTER/EXECUTEI.
REQ-010 mem_ready  in  1  memory access complete this cycle.
REQ-011 Outputs, 1 bit each: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA.
REQ-012 Outputs, 2 bits each: ALUSrcB, ResultSrc, ImmSrc, RegSrc.
REQ-013 ALUControl  out  ALU_CTRL_W  ALU operation.
REQ-014 Flags  out  4  stored {N,Z,C,V}.

Function
REQ-015 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-016 Outputs are Moore decodes of state, except the CondEx/NoWrite/mem_ready gating below; all unlisted outputs are 0.
REQ-017 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; IRWrite=PCWrite=mem_ready; leave for DECODE only when mem_ready=1.
REQ-018 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state: Op=01 -> MEMADR; Op=00 with I=0 -> EXECUTER; Op=00 with I=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH with no writes.
REQ-019 ImmSrc=Op and RegSrc={Op==01 & L==0, Op==10}, held in every state.
REQ-020 MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next state MEMREAD if L=1, else MEMWRITE.
REQ-021 MEMREAD: AdrSrc=1; stay until mem_ready, then MEMWB.
REQ-022 MEMWB: ResultSrc=01, RegWrite=CondEx, PCWrite=CondEx & (Rd==15); next FETCH.
REQ-023 MEMWRITE: AdrSrc=1, MemWrite=CondEx held until mem_ready; then FETCH.
REQ-024 EXECUTER: ALUSrcA=0, ALUSrcB=00. EXECUTEI: ALUSrcA=0, ALUSrcB=01. Both go to ALUWB.
REQ-025 ALU decode by cmd: 0100 ADD -> 00; 0010 SUB -> 01; 0000 AND -> 10; 1100 ORR -> 11; 1010 CMP -> 01 with NoWrite=1. When ALU_CTRL_W=3: 0001 EOR -> 100 and the other codes are zero-extended.
REQ-026 Any other cmd: ALUControl=0, FlagW=00, NoWrite=1.
REQ-027 FlagW: S=0 gives 00 (CMP always 11). Otherwise ADD/SUB/CMP give 11 and logic ops give 10.
REQ-028 Flag latching: on the edge leaving EXECUTER/EXECUTEI, if CondEx: FlagW[1] loads N,Z and FlagW[0] loads C,V.
REQ-029 ALUWB: ResultSrc=00; RegWrite=CondEx & ~NoWrite; PCWrite=CondEx & ~NoWrite & (Rd==15); next FETCH.
REQ-030 BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx; next FETCH.
REQ-031 CondEx is evaluated from Cond against the stored Flags, never against live ALUFlags. Cond codes follow the standard ARM EQ..LE table; 1110=AL gives 1; 1111 gives 0.
REQ-032 Cycle counts with mem_ready constant 1: data-processing 4, LDR 5, STR 4, branch 3.

Reset
REQ-033 Asserting reset at any point, including mid-access, forces FETCH and Flags=0000 immediately.
REQ-034 While reset is asserted, all write strobes are 0.
REQ-035 After reset is released, the first fetch begins on the next rising edge.

Structure
REQ-036 Shared package ctrl_pkg holds: state encoding, ALU op codes, cond-code constants, and the ResultSrc/ALUSrcB encodings.
REQ-037 One combinational sub-module, cond_check (Cond, Flags -> CondEx); flag storage stays in the top.

Verification
REQ-038 Reset, then ADD R1,R2,R3 (Cond=1110, Funct=001000), mem_ready=1 -> FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 in cycle 4.
REQ-039 SUBS with ALUFlags=0100, then BEQ -> Flags=0100; BRANCH PCWrite=1. Repeat with BNE -> PCWrite=0.
REQ-040 LDR with mem_ready held low for 3 cycles in MEMREAD -> remains MEMREAD for 4 cycles, then MEMWB RegWrite=1.
REQ-041 CMP (cmd 1010) -> ALUControl=01, Flags updated, RegWrite=0 in ALUWB. ADD with Rd=15 -> PCWrite=1 in ALUWB.
REQ-042 Reset pulsed during MEMWRITE -> MemWrite=0 immediately, state FETCH, Flags=0000.
REQ-043 ALU_CTRL_W=3 with EOR -> ALUControl=100; Op=11 -> DECODE returns to FETCH with no writes.
